// File: rtl/spike_synapse_pkg.sv
// Shared types and constants for the spike_synapse front-end.
package spike_synapse_pkg;

  typedef enum logic {
    SCAN   = 1'b0,
    UPDATE = 1'b1
  } state_e;

  localparam int CURRENT_W   = 8;
  localparam int CURRENT_MAX = 255;

  // One guard bit above the worst-case sum of N full-scale weights.
  function automatic int acc_width(input int n_inputs);
    return CURRENT_W + $clog2(n_inputs) + 1;
  endfunction

endpackage

// File: rtl/spike_synapse_weights.sv
// Synaptic weight register file: one write port, one combinational read port.
module spike_synapse_weights
  import spike_synapse_pkg::*;
#(
  parameter int N_INPUTS    = 4,
  parameter int WEIGHT_INIT = 0,
  localparam int PW         = $clog2(N_INPUTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [PW-1:0]        wr_addr_i,
  input  logic [CURRENT_W-1:0] wr_data_i,
  input  logic [PW-1:0]        rd_addr_i,
  output logic [CURRENT_W-1:0] rd_data_o
);

  logic [N_INPUTS-1:0][CURRENT_W-1:0] w_q, w_d;

  // Per-entry decode; addresses with no matching entry simply hit nothing.
  for (genvar k = 0; k < N_INPUTS; k++) begin : g_entry
    always_comb begin
      w_d[k] = w_q[k];
      if (wr_en_i && (wr_addr_i == PW'(k))) w_d[k] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) w_q <= {N_INPUTS{CURRENT_W'(WEIGHT_INIT)}};
    else       w_q <= w_d;
  end

  assign rd_data_o = w_q[rd_addr_i];

endmodule

// File: rtl/spike_synapse.sv
// Time-multiplexed synaptic integrator with exponential current decay.
// Define SYNAPSE_INHIBIT_EN to treat weight bit 7 as an inhibitory flag.
module spike_synapse
  import spike_synapse_pkg::*;
#(
  parameter int N_INPUTS    = 4,
  parameter int DECAY_SHIFT = 2,
  parameter int WEIGHT_INIT = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_INPUTS-1:0]         spike_i,
  input  logic                        wr_en_i,
  input  logic [$clog2(N_INPUTS)-1:0] wr_addr_i,
  input  logic [7:0]                  wr_data_i,
  output logic [7:0]                  current_o,
  output logic                        frame_o
);

  localparam int PW = $clog2(N_INPUTS);
  localparam int AW = acc_width(N_INPUTS);
  localparam int SW = AW + 2;

  state_e                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [N_INPUTS-1:0]   pend_q, pend_d;
  logic [CURRENT_W-1:0]  current_q, current_d;
  logic                  frame_q, frame_d;
  logic [CURRENT_W-1:0]  w_rd, decayed, clamped;
  logic                  neg;

`ifdef SYNAPSE_INHIBIT_EN
  logic signed [AW-1:0] acc_q, acc_d, addend;
  logic signed [SW-1:0] sum;
`else
  logic [AW-1:0] acc_q, acc_d, addend;
  logic [SW-1:0] sum;
`endif

  spike_synapse_weights #(
    .N_INPUTS    (N_INPUTS),
    .WEIGHT_INIT (WEIGHT_INIT)
  ) u_weights (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (ptr_q),
    .rd_data_o (w_rd)
  );

  always_comb begin
    decayed = current_q - (current_q >> DECAY_SHIFT);
`ifdef SYNAPSE_INHIBIT_EN
    addend = w_rd[7] ? -$signed({{(AW-7){1'b0}}, w_rd[6:0]})
                     :  $signed({{(AW-7){1'b0}}, w_rd[6:0]});
    sum    = $signed({{(SW-CURRENT_W){1'b0}}, decayed})
           + $signed({{(SW-AW){acc_q[AW-1]}}, acc_q});
    neg    = sum[SW-1];
`else
    addend = {{(AW-CURRENT_W){1'b0}}, w_rd};
    sum    = {{(SW-CURRENT_W){1'b0}}, decayed} + {{(SW-AW){1'b0}}, acc_q};
    neg    = 1'b0;
`endif
    if (neg)                          clamped = '0;
    else if (sum > SW'(CURRENT_MAX))  clamped = CURRENT_W'(CURRENT_MAX);
    else                              clamped = sum[CURRENT_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    acc_d     = acc_q;
    pend_d    = pend_q;
    current_d = current_q;
    frame_d   = 1'b0;
    case (state_q)
      SCAN: begin
        if (pend_q[ptr_q]) begin
          acc_d         = acc_q + addend;
          pend_d[ptr_q] = 1'b0;
        end
        if (ptr_q == PW'(N_INPUTS - 1)) state_d = UPDATE;
        else                            ptr_d   = ptr_q + 1'b1;
      end
      UPDATE: begin
        current_d = clamped;
        acc_d     = '0;
        ptr_d     = '0;
        frame_d   = 1'b1;
        state_d   = SCAN;
      end
      default: state_d = SCAN;
    endcase
    // New spikes win over the scan clear, so a same-cycle spike is kept for next frame.
    pend_d = pend_d | spike_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SCAN;
      ptr_q     <= '0;
      acc_q     <= '0;
      pend_q    <= '0;
      current_q <= '0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      acc_q     <= acc_d;
      pend_q    <= pend_d;
      current_q <= current_d;
      frame_q   <= frame_d;
    end
  end

  assign current_o = current_q;
  assign frame_o   = frame_q;

endmodule

// File: tb/tb_spike_synapse.sv
// Directed bench for spike_synapse with a frame-level behavioural reference model.
module tb_spike_synapse;

  localparam int N  = 4;
  localparam int DS = 2;
  localparam int WI = 0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] spike;
  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [7:0]   wr_data;
  logic [7:0]   current_o;
  logic         frame_o;

  int n_tests = 0;
  int n_fail  = 0;

  spike_synapse #(.N_INPUTS(N), .DECAY_SHIFT(DS), .WEIGHT_INIT(WI)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .spike_i   (spike),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .current_o (current_o),
    .frame_o   (frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame slots 0..N-1 consume input k, slot N applies the update.
  int m_w[N];
  int m_pend[N];
  int m_acc, m_cur, m_slot, m_frame;

  function automatic int wval(input int w);
`ifdef SYNAPSE_INHIBIT_EN
    if (w >= 128) return -(w - 128);
`endif
    return w;
  endfunction

  function automatic int clamp(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin m_w[k] = WI; m_pend[k] = 0; end
    m_acc = 0; m_cur = 0; m_slot = 0; m_frame = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        m_frame = 0;
        if (m_slot < N) begin
          if (m_pend[m_slot] != 0) begin
            m_acc = m_acc + wval(m_w[m_slot]);
            m_pend[m_slot] = 0;
          end
          m_slot++;
        end else begin
          m_cur = clamp(m_cur - m_cur / (1 << DS) + m_acc);
          m_acc = 0; m_slot = 0; m_frame = 1;
        end
        for (int k = 0; k < N; k++) begin
          if (spike[k]) m_pend[k] = 1;
          if (wr_en && int'(wr_addr) == k) m_w[k] = int'(wr_data);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_current", int'(current_o), m_cur);
      chk("model_frame", int'(frame_o), m_frame);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    spike = '0; wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 2'(a); wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_frame(output int v, output int cyc);
    bit seen = 0;
    v = -1; cyc = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (frame_o) begin seen = 1; v = int'(current_o); end
    end
    if (!seen) chk("frame_timeout", 0, 1);
  endtask

  task automatic next_nonzero(output int v);
    int c;
    v = 0;
    for (int i = 0; i < 6 && v <= 0; i++) wait_frame(v, c);
  endtask

  int v, c;
  int exp2[4] = '{30, 23, 18, 14};

  initial begin
    spike = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset: zero current, frame every N+1 cycles.
    chk("reset_current", int'(current_o), 0);
    chk("reset_frame", int'(frame_o), 0);
    for (int i = 0; i < 3; i++) begin
      wait_frame(v, c);
      chk("idle_period", c, 5);
      chk("idle_current", v, 0);
    end

    // Single spike decays geometrically.
    do_reset();
    wr(1, 40);
    spike = 4'b0010;
    @(negedge clk);
    spike = '0;
    next_nonzero(v);
    chk("decay_first", v, 40);
    for (int i = 0; i < 4; i++) begin
      wait_frame(v, c);
      chk("decay_seq", v, exp2[i]);
    end

    // Held spike counts once per frame.
    do_reset();
    wr(2, 10);
    spike = 4'b0100;
    next_nonzero(v);
    chk("held_1", v, 10);
    wait_frame(v, c); chk("held_2", v, 18);
    wait_frame(v, c); chk("held_3", v, 24);
    spike = '0;

    // Ceiling saturation.
    do_reset();
    for (int k = 0; k < N; k++) wr(k, 200);
    wait_frame(v, c);
    spike = 4'hF;
    next_nonzero(v);
    chk("sat_first", v, 255);
    for (int i = 0; i < 3; i++) begin
      wait_frame(v, c);
      chk("sat_hold", v, 255);
    end
    spike = '0;

    // Settle at 100, then switch to input 0 with weight 0xB2.
    do_reset();
    wr(3, 25);
    wr(0, 8'hB2);
    spike = 4'b1000;
    v = 0;
    for (int i = 0; i < 30 && v != 100; i++) wait_frame(v, c);
    chk("settle_100", v, 100);
    spike = 4'b0001;
    wait_frame(v, c); chk("switch_leftover", v, 100);
`ifdef SYNAPSE_INHIBIT_EN
    wait_frame(v, c); chk("inhib_first", v, 25);
    wait_frame(v, c); chk("inhib_floor", v, 0);
`else
    wait_frame(v, c); chk("excit_first", v, 253);
    wait_frame(v, c); chk("excit_ceiling", v, 255);
`endif
    spike = '0;

    // Asynchronous reset during a frame pulse with spikes pending.
    do_reset();
    wr(1, 40);
    spike = 4'hF;
    next_nonzero(v);
    chk("pre_reset_current", v, 40);
    #2 rst = 1'b1;
    #1;
    chk("async_current", int'(current_o), 0);
    chk("async_frame", int'(frame_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_frame(v, c);
    chk("post_reset_period", c, 5);
    chk("post_reset_current", v, 0);
    for (int i = 0; i < 2; i++) begin
      wait_frame(v, c);
      chk("weights_cleared", v, 0);
    end
    spike = '0;

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
